// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package mul_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_TERM = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth_multiplier_add_sub.sv
// Ripple-carry adder/subtractor for the Booth accumulator; sub inverts b and feeds carry-in.
module booth_add_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  logic [W-1:0] bx;
  logic [W-1:0] c;

  assign bx   = b ^ {W{sub}};
  assign c[0] = sub;

  // Final carry-out is dropped: the accumulator wraps modulo 2^W.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ bx[i] ^ c[i];
    if (i < W-1) begin : g_carry
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end
endmodule

// File: rtl/booth_multiplier.sv
// Radix-2 Booth sequential signed multiplier (IDLE -> RUN x8 -> DONE).
// Optional macro MUL_ZERO_SKIP_EN: zero operands bypass RUN and complete in one cycle.
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int AW = WIDTH + 1;

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  logic               sub;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      a_step;

  // {Q[0],Q_1} = 10 subtracts M, 01 adds M; the adder result is used only when they differ.
  assign sub = q_q[0] & ~q1_q;

  booth_add_sub #(.W(AW)) u_add_sub (
    .a   (a_q),
    .b   (m_q),
    .sub (sub),
    .sum (sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    a_step  = (q_q[0] ^ q1_q) ? sum : a_q;

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MUL_ZERO_SKIP_EN
          if ((x == '0) || (y == '0)) begin
            state_d = DONE;
            prod_d  = '0;
            done_d  = 1'b1;
          end else
`endif
          begin
            a_d     = '0;
            q_d     = y;
            q1_d    = 1'b0;
            m_d     = {x[WIDTH-1], x};
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d   = {a_step[AW-1], a_step[AW-1:1]};
        q_d   = {a_step[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        // Product is captured on the transition so it is valid alongside the done pulse.
        if (cnt_d == CNT_TERM) begin
          state_d = DONE;
          done_d  = 1'b1;
          prod_d  = {a_d[WIDTH-1:0], q_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign prod = prod_q;
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; this spec fixes values at WIDTH=8.
- REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
- REQ-003 The block SHALL have port rst_b, input, 1, a synchronous active-low reset.
- REQ-004 The block SHALL have port start, input, 1, the request to begin a multiplication.
- REQ-005 The block SHALL have port x, input, 8, the multiplicand M (two's complement).
- REQ-006 The block SHALL have port y, input, 8, the multiplier Q (two's complement).
- REQ-007 The block SHALL have port busy, output, 1, high while iterating.
- REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
- REQ-009 The block SHALL have port prod, output, 16, the signed product x*y.

Function
- REQ-010 The block SHALL implement a radix-2 Booth sequential multiplier with three states: IDLE, RUN and DONE.
- REQ-011 In IDLE with start=1, the block SHALL load the following, set the step count cnt=0, and go to RUN:
  - A = 0 (9 bit)
  - Q = y
  - Q_1 = 0
  - M = sign-extended x (9 bit)
- REQ-012 In each RUN cycle the block SHALL first update A from {Q[0],Q_1}, then arithmetic-right-shift {A,Q,Q_1} by 1 and increment cnt:
  - 01: A = A + M
  - 10: A = A - M, computed as A + ~M + 1
  - 00 or 11: A unchanged
- REQ-013 After exactly 8 RUN cycles (cnt reaching 8) the block SHALL go to DONE.
- REQ-014 In DONE the block SHALL register prod = {A[7:0],Q} and assert done for that single cycle, then return to IDLE.
- REQ-015 Latency: the block SHALL assert done exactly 9 cycles after the cycle in which start was sampled high.
- REQ-016 busy SHALL be high only in RUN; it SHALL be low in IDLE and in DONE.
- REQ-017 The block SHALL sample x and y only on acceptance; operand changes during RUN SHALL have no effect.
- REQ-018 The block SHALL ignore start in RUN and in DONE; back-to-back operations therefore have a minimum spacing of 10 cycles.
- REQ-019 prod SHALL hold its last value until the next DONE.
- REQ-020 All 9-bit additions SHALL wrap modulo 2^9; the full 8x8 signed range, including -128*-128 = +16384, SHALL be exact in 16 bits.

Reset
- REQ-021 On rst_b=0 at a clock edge, the block SHALL, from any state including mid-RUN, abandon the operation without asserting done and set:
  - state = IDLE
  - busy = 0
  - done = 0
  - prod = 0
  - A, Q, Q_1, M, cnt = 0
- REQ-022 If rst_b=0 and start=1 in the same cycle, reset SHALL win; start SHALL be honoured from the first cycle with rst_b=1.

Configuration
- REQ-023 The block SHALL support macro MUL_ZERO_SKIP_EN.
- REQ-024 With MUL_ZERO_SKIP_EN defined, an accepted start with x==0 or y==0 SHALL go from IDLE directly to DONE with prod=0 and done asserted 1 cycle after acceptance; busy SHALL stay low.
- REQ-025 Without MUL_ZERO_SKIP_EN, every operation SHALL take 8 RUN cycles per REQ-015, with no zero detection logic present.

Structure
- REQ-026 Package mul_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE)
  - WIDTH default
  - the 4-bit step-count width
  - the step-count terminal constant 8
- REQ-027 The 9-bit add/subtract SHALL be a sub-module booth_add_sub (inputs a, b, sub; output sum) built from a full-adder ripple chain; sub inverts b and drives carry-in.

Verification
- REQ-028 Scenario: x=7, y=3, start pulse -> busy high 8 cycles, done 9 cycles later, prod=16'h0015.
- REQ-029 Scenario: x=-128, y=-128 -> prod=16'h4000; x=-5, y=6 -> prod=16'hFFE2; x=127, y=-128 -> prod=16'hC080.
- REQ-030 Scenario: start held high for 20 cycles with x=2, y=3 -> exactly two done pulses 10 cycles apart, each with prod=16'h0006.
- REQ-031 Scenario: start with x=9, y=9, then rst_b=0 at RUN cycle 4 -> no done, busy=0 and prod=0 next cycle; a new start with x=9, y=9 then gives prod=16'h0051.
- REQ-032 Scenario: x=0, y=-1 -> prod=0:
  - with MUL_ZERO_SKIP_EN: done 1 cycle after start, busy never high
  - without MUL_ZERO_SKIP_EN: done after 9 cycles
- REQ-033 Scenario: change x and y every cycle during RUN after start with x=-3, y=-4 -> prod=16'h000C.
